subleq_core: RTL and testbench
==============================

# subleq_core

- Single-instruction (SUBLEQ) execution core.
- Sits directly upstream of the dual-port word memory and drives both of its ports.
- Each instruction occupies three consecutive words A, B, C:
  - computes mem[B] ← mem[B] − mem[A];
  - branches to C if the result is ≤ 0 (signed), otherwise continues at pc+3.
- Uses a fixed 4-cycle FSM sized around the memory's one-cycle registered read latency.

## Interface
- RESET_PC, 0: pc loaded on reset.
- CNT_WIDTH, 32: width of the retired-instruction counter.
- clk  in  1: single clock; all state changes on rising edge.
- rst  in  1: reset, synchronous, active-high.
- run  in  1: level; leaving IDLE requires run=1.
- add1  out  gc::WORD_SIZE: memory port 1 address (read-only use).
- dataIn1  out  gc::WORD_SIZE: tied 0.
- write1  out  1: tied 0.
- dataOut1  in  gc::WORD_SIZE: port 1 read data, valid the cycle after its address.
- add2  out  gc::WORD_SIZE: memory port 2 address.
- dataIn2  out  gc::WORD_SIZE: write-back data.
- write2  out  1: write strobe, high only in EXEC.
- dataOut2  in  gc::WORD_SIZE: port 2 read data, valid the cycle after its address.
- pc  out  gc::WORD_SIZE: address of the current instruction.
- halted  out  1: core in HALT.
- retired  out  CNT_WIDTH: count of completed instructions.

## Operation
- States: IDLE, FETCH, OPER, TGT, EXEC, HALT.
- IDLE:
  - no memory access;
  - → FETCH when run=1.
- FETCH: add1=pc, add2=pc+1.
- OPER:
  - latch regA=dataOut1, regB=dataOut2;
  - add1=dataOut1, add2=dataOut2.
- TGT:
  - latch opA=dataOut1, opB=dataOut2;
  - add1=pc+2.
- EXEC:
  - latch regC=dataOut1;
  - diff=opB−opA;
  - write2=1, add2=regB, dataIn2=diff.
- EXEC outcome:
  - if diff[MSB]=1 or diff=0: branch taken, next pc=dataOut1;
  - otherwise next pc=pc+3;
  - retired increments.
- EXEC next state:
  - HALT if branch taken and dataOut1[MSB]=1 (negative target);
  - else FETCH if run=1;
  - else IDLE.
- HALT:
  - no memory writes, pc frozen, halted=1;
  - exit only via rst.
- Arithmetic:
  - diff, pc+1, pc+2 and pc+3 all wrap modulo 2^WORD_SIZE;
  - the sign test uses the truncated diff only (no overflow detection).
- Addresses are not range-checked against gc::MEM_SIZE; that is the program's responsibility.
- In non-write cycles, dataIn2=0 and unused addresses hold 0.
- Self-modifying code:
  - the EXEC write lands at the EXEC edge;
  - the following FETCH reads the updated memory.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, retired=0, halted=0, regA/regB/regC/opA/opB=0.
- Port outputs are combinational from state and registers. write2 is gated with !rst, so a reset asserted during EXEC performs no write and leaves pc unchanged.
- rst has priority over run and over every transition, in every state.
- Instruction latency:
  - exactly 4 cycles, FETCH→EXEC;
  - back-to-back with run held high, giving one instruction per 4 clocks.
- Dropping run only takes effect at an instruction boundary (EXEC→IDLE). Mid-instruction, run is ignored.
- pc, retired and halted update on the EXEC edge. Their new values are visible in the following cycle.

## Structure
- In package gc:
  - the state enum type subleq_state_t;
  - reuse the existing WORD_SIZE and MEM_SIZE;
  - no new constants.
- Sub-module: none; the datapath is too small to split. The bench instantiates subleq_core against the existing memory module.

## Test plan
Benches use WORD_SIZE=16.
- Reset:
  - stimulus: rst=1 for 2 cycles, run=0;
  - required: pc=0, halted=0, retired=0, write2=0, core stays IDLE with add1=add2=0.
- Fall-through:
  - stimulus: mem[0..2]={9,10,6}, mem[9]=5, mem[10]=7, run=1;
  - required: EXEC in cycle 4 with write2=1, add2=10, dataIn2=2;
  - then pc=3, retired=1, mem[10]=2.
- Branch taken:
  - stimulus: as above with mem[9]=7, mem[10]=5;
  - required: dataIn2=0xFFFE, pc=6.
  - Variant mem[9]=mem[10]=5: dataIn2=0, pc=6.
- Wrap:
  - stimulus: mem[9]=1, mem[10]=0x8000;
  - required: dataIn2=0x7FFF, no branch, pc=3.
- Halt:
  - stimulus: taken branch with C=0xFFFF;
  - required: halted=1, pc unchanged;
  - no further write2 pulses while run stays 1 for 20 cycles.
- Reset during EXEC:
  - stimulus: rst=1 in the EXEC cycle of the fall-through program;
  - required: write2=0 that cycle, mem[10] stays 7, next cycle pc=0, retired=0.

Source files
------------

// File: rtl/subleq_core_pkg.sv
// Shared word/memory sizing and the SUBLEQ core state encoding.
package gc;
  localparam int WORD_SIZE = 16;
  localparam int MEM_SIZE  = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPER,
    S_TGT,
    S_EXEC,
    S_HALT
  } subleq_state_t;
endpackage

// File: rtl/subleq_core_if.sv
// Dual-port word memory bus: the core is the master, the memory is the slave.
interface subleq_core_if;
  logic [gc::WORD_SIZE-1:0] add1;
  logic [gc::WORD_SIZE-1:0] dataIn1;
  logic                     write1;
  logic [gc::WORD_SIZE-1:0] dataOut1;
  logic [gc::WORD_SIZE-1:0] add2;
  logic [gc::WORD_SIZE-1:0] dataIn2;
  logic                     write2;
  logic [gc::WORD_SIZE-1:0] dataOut2;

  modport master (
    output add1, dataIn1, write1, add2, dataIn2, write2,
    input  dataOut1, dataOut2
  );

  modport slave (
    input  add1, dataIn1, write1, add2, dataIn2, write2,
    output dataOut1, dataOut2
  );
endinterface

// File: rtl/subleq_core.sv
// SUBLEQ execution core: mem[B] -= mem[A]; branch to C if result <= 0.
// Fixed FETCH/OPER/TGT/EXEC sequence around a one-cycle registered memory read.
module subleq_core
  import gc::*;
#(
  parameter logic [gc::WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                       CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  subleq_core_if.master        mem,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  subleq_state_t          r_state;
  logic [WORD_SIZE-1:0]   r_pc;
  logic [CNT_WIDTH-1:0]   r_retired;
  logic                   r_halted;
  logic [WORD_SIZE-1:0]   r_regB;
  logic signed [WORD_SIZE-1:0] r_opA;
  logic signed [WORD_SIZE-1:0] r_opB;

  logic signed [WORD_SIZE-1:0] w_diff;
  logic                        w_taken;
  logic                        w_halt_tgt;

  // Sign test is on the truncated difference only; overflow is not detected.
  assign w_diff     = r_opB - r_opA;
  assign w_taken    = w_diff[WORD_SIZE-1] || (w_diff == '0);
  assign w_halt_tgt = mem.dataOut1[WORD_SIZE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_regB    <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (run) r_state <= S_FETCH;
        S_FETCH: r_state <= S_OPER;
        S_OPER: begin
          r_regB  <= mem.dataOut2;
          r_state <= S_TGT;
        end
        S_TGT: begin
          r_opA   <= mem.dataOut1;
          r_opB   <= mem.dataOut2;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_retired <= r_retired + CNT_WIDTH'(1);
          // A taken branch to a negative target halts with pc left on the halting instruction.
          if (w_taken && w_halt_tgt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_pc    <= w_taken ? mem.dataOut1 : r_pc + WORD_SIZE'(3);
            r_state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.add1    = '0;
    mem.dataIn1 = '0;
    mem.write1  = 1'b0;
    mem.add2    = '0;
    mem.dataIn2 = '0;
    mem.write2  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem.add1 = r_pc;
        mem.add2 = r_pc + WORD_SIZE'(1);
      end
      S_OPER: begin
        mem.add1 = mem.dataOut1;
        mem.add2 = mem.dataOut2;
      end
      S_TGT:   mem.add1 = r_pc + WORD_SIZE'(2);
      S_EXEC: begin
        // Gated by rst so a reset landing on EXEC never commits a write.
        mem.add1    = r_pc + WORD_SIZE'(2);
        mem.add2    = r_regB;
        mem.write2  = !rst;
        mem.dataIn2 = rst ? '0 : w_diff;
      end
      default: ;
    endcase
  end

  assign pc      = r_pc;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench for subleq_core against a behavioural dual-port registered-read memory.
module tb_subleq_core;
  localparam int W = gc::WORD_SIZE;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic [W-1:0] pc;
  logic         halted;
  logic [31:0]  retired;

  logic         clr   = 1'b0;
  logic         ld_we = 1'b0;
  logic [W-1:0] ld_a  = '0;
  logic [W-1:0] ld_d  = '0;
  logic [W-1:0] mem [0:gc::MEM_SIZE-1];

  int n_cmp = 0;
  int n_bad = 0;

  subleq_core_if bus ();

  subleq_core #(.RESET_PC('0), .CNT_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .mem     (bus),
    .pc      (pc),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [W-1:0] a);
    return int'(a) % gc::MEM_SIZE;
  endfunction

  // Memory model: writes and reads both registered on the rising edge.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < gc::MEM_SIZE; i++) mem[i] <= '0;
    end else if (ld_we) begin
      mem[idx(ld_a)] <= ld_d;
    end else if (bus.write2) begin
      mem[idx(bus.add2)] <= bus.dataIn2;
    end
    bus.dataOut1 <= mem[idx(bus.add1)];
    bus.dataOut2 <= mem[idx(bus.add2)];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [W-1:0] a, input logic [W-1:0] d);
    ld_we = 1'b1; ld_a = a; ld_d = d;
    tick();
    ld_we = 1'b0;
  endtask

  // Holds reset, loads A,B,C at 0..2 and operands at 9/10, then releases with run=1
  // and returns how many cycles elapse until the first write strobe.
  task automatic start_prog(input logic [W-1:0] c, input logic [W-1:0] ma,
                            input logic [W-1:0] mb, output int cyc, output bit ok);
    rst = 1'b1; run = 1'b0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    poke(16'd0, 16'd9);
    poke(16'd1, 16'd10);
    poke(16'd2, c);
    poke(16'd9, ma);
    poke(16'd10, mb);
    tick();
    tick();
    rst = 1'b0; run = 1'b1;
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      cyc++;
      if (bus.write2) ok = 1'b1;
    end
  endtask

  // Runs one instruction with run dropped at EXEC and checks the committed outcome.
  task automatic one_instr(input string tag, input logic [W-1:0] c, input logic [W-1:0] ma,
                           input logic [W-1:0] mb, input logic [W-1:0] exp_diff,
                           input logic [W-1:0] exp_pc);
    int cyc;
    bit ok;
    start_prog(c, ma, mb, cyc, ok);
    check_val({tag, "_exec_seen"}, 32'(ok), 32'd1);
    check_val({tag, "_latency"}, 32'(cyc), 32'd4);
    check_val({tag, "_add2"}, 32'(bus.add2), 32'd10);
    check_val({tag, "_dataIn2"}, 32'(bus.dataIn2), 32'(exp_diff));
    run = 1'b0;
    tick();
    check_val({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check_val({tag, "_retired"}, retired, 32'd1);
    check_val({tag, "_mem10"}, 32'(mem[10]), 32'(exp_diff));
    check_val({tag, "_write2_after"}, 32'(bus.write2), 32'd0);
  endtask

  initial begin
    int cyc;
    bit ok;
    int pulses;

    // Reset with run low: core idles, no memory traffic.
    rst = 1'b1; run = 1'b0;
    tick(); tick();
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_halted", 32'(halted), 32'd0);
    check_val("rst_retired", retired, 32'd0);
    check_val("rst_write2", 32'(bus.write2), 32'd0);
    check_val("rst_write1", 32'(bus.write1), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_val("idle_add1", 32'(bus.add1), 32'd0);
    check_val("idle_add2", 32'(bus.add2), 32'd0);
    check_val("idle_write2", 32'(bus.write2), 32'd0);
    check_val("idle_pc", 32'(pc), 32'd0);

    one_instr("fall", 16'd6, 16'd5, 16'd7, 16'd2, 16'd3);
    one_instr("taken", 16'd6, 16'd7, 16'd5, 16'hFFFE, 16'd6);
    one_instr("zero", 16'd6, 16'd5, 16'd5, 16'd0, 16'd6);
    one_instr("wrap", 16'd6, 16'd1, 16'h8000, 16'h7FFF, 16'd3);

    // Taken branch to a negative target halts; run stays high afterwards.
    start_prog(16'hFFFF, 16'd7, 16'd5, cyc, ok);
    check_val("halt_exec_seen", 32'(ok), 32'd1);
    check_val("halt_dataIn2", 32'(bus.dataIn2), 32'h0000FFFE);
    tick();
    check_val("halt_halted", 32'(halted), 32'd1);
    check_val("halt_pc", 32'(pc), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.write2) pulses++;
      tick();
    end
    check_val("halt_no_writes", 32'(pulses), 32'd0);
    check_val("halt_still", 32'(halted), 32'd1);
    check_val("halt_pc_frozen", 32'(pc), 32'd0);

    // Reset landing on the EXEC cycle suppresses the write and the commit.
    start_prog(16'd6, 16'd5, 16'd7, cyc, ok);
    check_val("rexec_exec_seen", 32'(ok), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rexec_write2", 32'(bus.write2), 32'd0);
    @(posedge clk);
    #1;
    check_val("rexec_mem10", 32'(mem[10]), 32'd7);
    check_val("rexec_pc", 32'(pc), 32'd0);
    check_val("rexec_retired", retired, 32'd0);
    check_val("rexec_halted", 32'(halted), 32'd0);
    rst = 1'b0; run = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
